mem_arbiter: RTL
================

# mem_arbiter

Shared-memory controller that multiplexes the single combinational RAM port between the instruction-fetch requester and the data (load/store) requester of the CPU. It registers each request, drives the RAM strobes for exactly one cycle per access, and performs read-modify-write for partial-word stores, since the RAM only accepts whole-word writes. It sits between the CPU core and the RAM. Each requester sees a waitrequest-style handshake.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width; fixed at 32 (4 byte lanes)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  **synchronous, active-low reset**
- i_addr  in  ADDR_W  instruction byte address
- i_read  in  1  instruction read request
- i_readdata  out  DATA_W  fetched word; valid only while i_waitrequest=0
- i_waitrequest  out  1  low for exactly the completion cycle
- d_addr  in  ADDR_W  data byte address
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_byteenable  in  4  write lane enables; lane k = bits 8k+7:8k
- d_writedata  in  DATA_W  store data
- d_readdata  out  DATA_W  load word; valid only while d_waitrequest=0
- d_waitrequest  out  1  low for exactly the completion cycle
- mem_addr  out  32  RAM byte address
- mem_data_in  out  32  RAM write data
- mem_data_read  out  1  RAM read strobe
- mem_data_write  out  1  RAM write strobe
- mem_data_out  in  32  RAM read data; combinational from mem_addr

## Operation
- FSM states:
  - IDLE
  - I_RD, I_ACK
  - D_RD, D_ACK
  - D_RMW_RD, D_WR
- In IDLE, pending requests are arbitrated. The winner's addr, writedata and byteenable are captured into registers. Later input changes are ignored until ACK.
- Instruction read: IDLE -> I_RD -> I_ACK -> IDLE.
- Data read: IDLE -> D_RD -> D_ACK -> IDLE.
- Full write (byteenable=4'hF): IDLE -> D_WR -> D_ACK -> IDLE.
- Partial write: IDLE -> D_RMW_RD -> D_WR -> D_ACK.
  - In D_RMW_RD, the RAM word is captured.
  - Enabled lanes take d_writedata; all other lanes keep the old bytes.
- byteenable=4'h0 write: IDLE -> D_ACK directly; no RAM access.
- d_read and d_write both high: treated as a write; no read is performed; d_readdata = 0 at ack.
- Addresses are word-aligned: mem_addr = {addr[31:2],2'b00}.
- RAM is little-endian: byte 0 is at the lowest address.
- Strobes are decoded from the state register:
  - mem_data_read=1 only in I_RD, D_RD and D_RMW_RD.
  - mem_data_write=1 only in D_WR.
  - The two strobes are never high together.
  - In all other states, mem_addr, mem_data_in and both strobes are 0.
- Read data is registered from mem_data_out at the end of the *_RD cycle. i_readdata and d_readdata are 0 outside their ACK cycles.
- Arbitration (default, fixed priority): data beats instruction when both are pending in IDLE.
- A requester that deasserts mid-transaction still gets its access completed and acked. No abort.

## Timing
- Request sampled in IDLE at cycle T. Completion (waitrequest=0):
  - Read: T+2
  - Full write: T+2
  - Partial write: T+3
  - Zero-byteenable write: T+1
- Controller returns to IDLE at completion+1. Back-to-back requests from one master start every 3 cycles (reads, full writes).
- Reset values (registered on the first clk edge with rst_n=0):
  - state=IDLE
  - i_waitrequest=1, d_waitrequest=1
  - i_readdata=0, d_readdata=0
  - all mem_* outputs = 0
  - round-robin pointer = "instruction last"
- Reset mid-operation: the state goes to IDLE at that edge. Strobes drop in the same cycle. No ack is issued for the aborted transaction.
- A partial write interrupted by reset in D_RMW_RD leaves RAM unchanged.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - When both requesters are pending in IDLE, grant the one not granted most recently.
  - The pointer updates on each grant.
  - After reset, data wins the first tie.
- ARB_ROUND_ROBIN_EN undefined: fixed data priority. Instruction fetch may starve under continuous data traffic.

## Test plan
- Reset held for 2 cycles, then released with no requests -> both waitrequest=1, all mem_* = 0, readdata=0.
- RAM[0x100..0x103] = 11,22,33,44; i_read at 0x102 -> mem_addr=0x100 in I_RD; i_readdata=0x44332211 with i_waitrequest=0 at T+2.
- d_write 0x100, be=4'b0101, wdata=0xAABBCCDD over a word of 0x44332211 -> one read cycle then one write cycle; RAM word becomes 0x44BB22DD; ack at T+3.
- i_read and d_read asserted together, held for 6 transactions:
  - Macro undefined: every grant goes to data.
  - ARB_ROUND_ROBIN_EN defined: grants alternate D, I, D, I…
- rst_n driven low during D_WR of a full write to 0x104 -> state=IDLE next cycle; no d_waitrequest=0 pulse; mem_data_write=0 from that edge.
- d_write with be=4'h0 -> ack at T+1; mem_data_read and mem_data_write stay 0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational RAM port between an instruction-fetch
// requester and a data (load/store) requester. Each access is registered in
// IDLE and then replayed on the RAM for exactly one strobe cycle. Partial-word
// stores become a read-modify-write because the RAM only takes whole words.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   i_addr, i_read             instruction fetch request (byte address)
//   i_readdata, i_waitrequest  fetched word, low-for-one-cycle completion
//   d_addr, d_read, d_write    data request (byte address)
//   d_byteenable, d_writedata  store lanes (lane k = bits 8k+7:8k) and data
//   d_readdata, d_waitrequest  load word, low-for-one-cycle completion
//   mem_addr, mem_data_in      word-aligned RAM address and write data
//   mem_data_read/write        RAM strobes, decoded from the state register
//   mem_data_out               RAM read data (combinational from mem_addr)
//
// Build option
//   ARB_ROUND_ROBIN_EN         defined: round-robin on ties (data wins first);
//                              undefined: data always beats instruction.

module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_waitrequest,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [3:0]        d_byteenable,
   input  logic [DATA_W-1:0] d_writedata,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_waitrequest,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_data_in,
   output logic              mem_data_read,
   output logic              mem_data_write,
   input  logic [31:0]       mem_data_out
);

   typedef enum logic [2:0] {
      IDLE,
      I_RD,
      I_ACK,
      D_RD,
      D_ACK,
      D_RMW_RD,
      D_WR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        be_q;
   logic [31:0]       word_addr;
   logic [31:0]       merged;
   logic              d_req;
   logic              grant_d;
   logic              unused_addr_lsbs;

`ifdef ARB_ROUND_ROBIN_EN
   logic              last_i;   // 1: instruction was granted most recently
`endif

   assign word_addr        = 32'({addr_q[ADDR_W-1:2], 2'b00});
   assign unused_addr_lsbs = ^addr_q[1:0];

   always_comb begin
      d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = d_req & (~i_read | last_i);
`else
      grant_d = d_req;
`endif
   end

   // Enabled lanes take the new store data, the rest keep the RAM's old bytes.
   always_comb begin
      merged = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : mem_data_out[8*k +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         i_readdata <= '0;
         d_readdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_i     <= 1'b1;
`endif
      end else begin
         // Read data is only non-zero during its ACK cycle.
         i_readdata <= '0;
         d_readdata <= '0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  addr_q  <= d_addr;
                  wdata_q <= d_writedata;
                  be_q    <= d_byteenable;
`ifdef ARB_ROUND_ROBIN_EN
                  last_i  <= 1'b0;
`endif
                  if (d_write) begin
                     if (d_byteenable == 4'h0)      state <= D_ACK;
                     else if (d_byteenable == 4'hF) state <= D_WR;
                     else                           state <= D_RMW_RD;
                  end else begin
                     state <= D_RD;
                  end
               end else if (i_read) begin
                  addr_q <= i_addr;
`ifdef ARB_ROUND_ROBIN_EN
                  last_i <= 1'b1;
`endif
                  state  <= I_RD;
               end
            end
            I_RD: begin
               i_readdata <= mem_data_out;
               state      <= I_ACK;
            end
            D_RD: begin
               d_readdata <= mem_data_out;
               state      <= D_ACK;
            end
            // The merged word replaces the captured store data for D_WR.
            D_RMW_RD: begin
               wdata_q <= merged;
               state   <= D_WR;
            end
            D_WR:    state <= D_ACK;
            I_ACK,
            D_ACK:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_addr       = '0;
      mem_data_in    = '0;
      mem_data_read  = 1'b0;
      mem_data_write = 1'b0;
      case (state)
         I_RD, D_RD, D_RMW_RD: begin
            mem_addr      = word_addr;
            mem_data_read = 1'b1;
         end
         D_WR: begin
            mem_addr       = word_addr;
            mem_data_in    = wdata_q;
            mem_data_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign i_waitrequest = (state != I_ACK);
   assign d_waitrequest = (state != D_ACK);

endmodule
